// File: rtl/uart_word_tx.sv
// Sends one 16-bit sensor word as two back-to-back 8N1 UART frames, high byte first.
// Latency: tx falls on the accept edge; shipping_done pulses 20*CLKS_PER_BIT cycles later.
// Backpressure: a request is taken only in IDLE; en_uart_tx is ignored while busy is high.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   en_uart_tx     level-sensitive send request from the scheduler
//   data_to_send   16-bit word, sampled only on the accept edge
//   tx             serial line, idles high
//   busy           high whenever the FSM is outside IDLE
//   shipping_done  one-cycle pulse after the second stop bit
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_uart_tx,
    input  logic [15:0] data_to_send,
    output logic        tx,
    output logic        busy,
    output logic        shipping_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [15:0]   shreg;
    logic          byte_sel;
    logic [2:0]    bit_idx;
    logic [CW-1:0] baud_cnt;

    logic [7:0]    cur_byte;
    logic          baud_last;

    // byte_sel = 0 is the high byte, which goes out first.
    assign cur_byte  = byte_sel ? shreg[7:0] : shreg[15:8];
    assign baud_last = (baud_cnt == BAUD_LAST);

    // tx is registered, so every transition loads the line level of the
    // state being entered; that keeps tx glitch-free and aligned with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            byte_sel      <= 1'b0;
            bit_idx       <= '0;
            baud_cnt      <= '0;
            tx            <= 1'b1;
            busy          <= 1'b0;
            shipping_done <= 1'b0;
        end else begin
            shipping_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (en_uart_tx) begin
                        shreg    <= data_to_send;
                        byte_sel <= 1'b0;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end

                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx       <= cur_byte[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (!byte_sel) begin
                            // Second frame starts with no idle gap.
                            byte_sel <= 1'b1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            tx            <= 1'b1;
                            shipping_done <= 1'b1;
                            state         <= DONE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DONE: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_uart_tx = 1'b1;
    logic [15:0] data_to_send = 16'hA55A;
    logic        tx;
    logic        busy;
    logic        shipping_done;

    uart_word_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .rst           (rst),
        .en_uart_tx    (en_uart_tx),
        .data_to_send  (data_to_send),
        .tx            (tx),
        .busy          (busy),
        .shipping_done (shipping_done)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    longint cyc     = 0;

    logic [7:0] exp_bytes[$];
    longint     exp_done[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // cycle counter: value N during the cycle that begins at the Nth rising edge
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART receiver monitor: samples mid-bit on falling edges, pops expected bytes
    initial begin
        logic       rx_act;
        int         rx_c;
        logic [9:0] rx_bits;
        logic [7:0] eb;
        rx_act  = 1'b0;
        rx_c    = 0;
        rx_bits = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_act = 1'b0;
                check("rst_tx", {63'd0, tx}, 64'd1);
                check("rst_busy", {63'd0, busy}, 64'd0);
                check("rst_done", {63'd0, shipping_done}, 64'd0);
            end else if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_c   = 0;
                end
            end else begin
                rx_c++;
                if (rx_c % CPB == CPB / 2) begin
                    rx_bits[rx_c / CPB] = tx;
                    if (rx_c / CPB == 9) begin
                        rx_act = 1'b0;
                        if (exp_bytes.size() == 0) begin
                            check("frame_unexpected", {54'd0, rx_bits}, 64'h3ff);
                        end else begin
                            eb = exp_bytes.pop_front();
                            check("frame", {54'd0, rx_bits}, {54'd0, 1'b1, eb, 1'b0});
                        end
                    end
                end
            end
        end
    end

    // shipping_done monitor: pulse time, busy during pulse, busy drop after
    initial begin
        logic busy_chk;
        longint ed;
        busy_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_chk) begin
                check("busy_drop", {63'd0, busy}, 64'd0);
                busy_chk = 1'b0;
            end
            if (!rst && shipping_done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", cyc, 64'hffff_ffff);
                end else begin
                    ed = exp_done.pop_front();
                    check("done_time", cyc, ed);
                    check("done_busy", {63'd0, busy}, 64'd1);
                    busy_chk = 1'b1;
                end
            end
        end
    end

    // drive point: 2 time units after a rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input longint c);
        while (cyc < c) tick();
    endtask

    task automatic measure_run(input logic level, output int len);
        len = 0;
        while (tx === level && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        longint acc;
        int     len;

        // reset held with a pending request; A55A goes out right after release
        repeat (3) tick();
        rst = 1'b0;
        acc = cyc + 1;
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'h5A);
        exp_done.push_back(acc + 80);
        tick();
        check("accept_tx", {63'd0, tx}, 64'd0);
        check("accept_busy", {63'd0, busy}, 64'd1);
        en_uart_tx = 1'b0;
        wait_until(acc + 82);
        check("idle_after_pulse", {63'd0, busy}, 64'd0);

        // 1234 accepted, data changes to FFFF with request held
        en_uart_tx   = 1'b1;
        data_to_send = 16'h1234;
        acc = cyc + 1;
        exp_bytes.push_back(8'h12);
        exp_bytes.push_back(8'h34);
        exp_done.push_back(acc + 80);
        exp_bytes.push_back(8'hFF);
        exp_bytes.push_back(8'hFF);
        exp_done.push_back(acc + 162);
        tick();
        data_to_send = 16'hFFFF;
        wait_until(acc + 81);
        check("gap_line", {63'd0, tx}, 64'd1);
        tick();
        check("second_start", {63'd0, tx}, 64'd0);
        check("second_busy", {63'd0, busy}, 64'd1);
        en_uart_tx = 1'b0;
        wait_until(acc + 82 + 84);

        // reset in the middle of the first data byte
        en_uart_tx   = 1'b1;
        data_to_send = 16'h00FF;
        acc = cyc + 1;
        tick();
        en_uart_tx = 1'b0;
        wait_until(acc + 15);
        check("pre_reset_tx", {63'd0, tx}, 64'd0);
        rst = 1'b1;
        #1;
        check("async_reset_tx", {63'd0, tx}, 64'd1);
        check("async_reset_busy", {63'd0, busy}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        en_uart_tx   = 1'b1;
        data_to_send = 16'hC3A5;
        acc = cyc + 1;
        exp_bytes.push_back(8'hC3);
        exp_bytes.push_back(8'hA5);
        exp_done.push_back(acc + 80);
        tick();
        en_uart_tx = 1'b0;
        wait_until(acc + 84);

        // all-zero word: long low runs
        en_uart_tx   = 1'b1;
        data_to_send = 16'h0000;
        acc = cyc + 1;
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00);
        exp_done.push_back(acc + 80);
        tick();
        en_uart_tx = 1'b0;
        @(negedge clk);
        measure_run(1'b0, len);
        check("zero_low1", len, 36);
        measure_run(1'b1, len);
        check("zero_stop1", len, 4);
        measure_run(1'b0, len);
        check("zero_low2", len, 36);
        wait_until(acc + 85);

        check("bytes_left", exp_bytes.size(), 0);
        check("done_left", exp_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
